// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with self-initialisation, write-through bypass and busy scoreboard
module regfile_sb #(
    parameter int             N        = 32,
    parameter int             DEPTH    = 32,
    parameter logic [N-1:0]   INIT_VAL = 1,
    parameter bit             ZERO_REG = 1'b1,
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [N-1:0]  rdata1,
    output logic [N-1:0]  rdata2,
    input  logic          mark_en,
    input  logic [AW-1:0] mark_addr,
    output logic          busy1,
    output logic          busy2,
    output logic          ready
);

    localparam int            SIZE = 1 << AW;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          ready_q, ready_d;
    logic [N-1:0]  mem_q [SIZE];
    logic [N-1:0]  mem_d [SIZE];
    logic [SIZE-1:0] busy_q, busy_d;

    // Entries that hold real, writable data: in range and not the hardwired zero register
    logic [SIZE-1:0] live;
    logic            run;
    logic            wr_ok;
    logic            mk_ok;

    // Address map of live entries; everything else reads 0 and is never written or marked
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            live[i] = (i < DEPTH) && !(ZERO_REG && (i == 0));
        end
    end

    // Qualified accesses: only honoured in RUN, never while reset is asserted
    always_comb begin
        run   = (state_q == S_RUN) && !rst;
        wr_ok = run && we && live[waddr];
        mk_ok = run && mark_en && live[mark_addr];
    end

    // Next-state: INIT sweeps every entry with INIT_VAL, RUN applies writes and scoreboard updates
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        for (int i = 0; i < SIZE; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (state_q == S_INIT) begin
            mem_d[idx_q] = INIT_VAL;
            if (idx_q == LAST) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            if (wr_ok) begin
                mem_d[waddr]  = wdata;
                busy_d[waddr] = 1'b0;
            end
            // Applied after the clear so a simultaneous mark to the same entry wins
            if (mk_ok) begin
                busy_d[mark_addr] = 1'b1;
            end
        end
    end

    // Control state, scoreboard and registered ready; reset restarts the init sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array has no reset; its contents become defined through the init sweep
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SIZE; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read ports with same-cycle bypass of a qualified write
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (run && live[raddr1]) begin
            rdata1 = (wr_ok && (waddr == raddr1)) ? wdata : mem_q[raddr1];
        end
        if (run && live[raddr2]) begin
            rdata2 = (wr_ok && (waddr == raddr2)) ? wdata : mem_q[raddr2];
        end
    end

    // Busy status drops in the cycle of the retiring write unless the same entry is re-marked
    always_comb begin
        busy1 = run && busy_q[raddr1]
                && !(wr_ok && (waddr == raddr1) && !(mk_ok && (mark_addr == raddr1)));
        busy2 = run && busy_q[raddr2]
                && !(wr_ok && (waddr == raddr2) && !(mk_ok && (mark_addr == raddr2)));
        ready = ready_q && !rst;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
module tb_regfile_sb;

    localparam int          N        = 32;
    localparam int          DEPTH    = 32;
    localparam logic [31:0] INIT_VAL = 32'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        mark_en;
    logic [4:0]  mark_addr;
    logic        busy1;
    logic        busy2;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    regfile_sb #(
        .N        (N),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL),
        .ZERO_REG (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .busy1     (busy1),
        .busy2     (busy2),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: cycles since reset, register contents and pending-write set
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    int          m_cnt   = 0;
    bit          m_known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1'b1;
            m_cnt   = 0;
            m_busy  = '0;
        end else if (m_known) begin
            if (m_cnt < DEPTH) begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    for (int i = 0; i < 32; i++) m_mem[i] = INIT_VAL;
                end
            end else begin
                if (we && waddr != 0) begin
                    m_mem[waddr]  = wdata;
                    m_busy[waddr] = 1'b0;
                end
                if (mark_en && mark_addr != 0) m_busy[mark_addr] = 1'b1;
            end
        end
    end

    function automatic logic m_ready();
        return m_known && (m_cnt == DEPTH) && !rst;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!m_ready() || a == 0) return 32'd0;
        if (we && waddr == a) return wdata;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!m_ready() || a == 0) return 1'b0;
        if (we && waddr == a && !(mark_en && mark_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_known) begin
            check("ready",  {31'd0, ready}, {31'd0, m_ready()});
            check("rdata1", rdata1, exp_rd(raddr1));
            check("rdata2", rdata2, exp_rd(raddr2));
            check("busy1",  {31'd0, busy1}, {31'd0, exp_busy(raddr1)});
            check("busy2",  {31'd0, busy2}, {31'd0, exp_busy(raddr2)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with ready low; also drops the INIT-time access attempts
    task automatic wait_ready(output int n);
        n = 0;
        while (n <= 100) begin
            @(negedge clk);
            if (ready === 1'b1) break;
            n++;
            @(posedge clk);
            #1;
            if (n == 16) begin
                we      = 1'b0;
                mark_en = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = 5'd5; raddr2 = 5'd0; mark_en = 1'b0; mark_addr = '0;

        tick();
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        tick();

        // Init sequence with write and mark attempts on r31 that must be ignored
        rst = 1'b0;
        we = 1'b1; waddr = 5'd31; wdata = 32'h55;
        mark_en = 1'b1; mark_addr = 5'd31;
        wait_ready(n);
        check("init_len", n, 32'd32);
        tick();

        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            @(negedge clk);
            check("init_rd", rdata1, (i == 0) ? 32'd0 : 32'd1);
            check("init_busy", {31'd0, busy1}, 32'd0);
            tick();
        end

        // Write-through bypass then hold
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5;
        @(negedge clk);
        check("bypass", rdata1, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("wr_hold", rdata1, 32'hDEADBEEF);
        tick();

        // Zero register ignores writes and marks
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr1 = 5'd0;
        mark_en = 1'b1; mark_addr = 5'd0;
        @(negedge clk);
        check("zr_rd", rdata1, 32'd0);
        tick();
        we = 1'b0; mark_en = 1'b0;
        @(negedge clk);
        check("zr_rd_later", rdata1, 32'd0);
        check("zr_busy", {31'd0, busy1}, 32'd0);
        tick();

        // Scoreboard: mark r7, retire it three edges later
        mark_en = 1'b1; mark_addr = 5'd7; raddr1 = 5'd7;
        @(negedge clk);
        check("busy_pre", {31'd0, busy1}, 32'd0);
        tick();
        mark_en = 1'b0;
        @(negedge clk);
        check("busy_set", {31'd0, busy1}, 32'd1);
        tick();
        tick();
        we = 1'b1; waddr = 5'd7; wdata = 32'h77;
        @(negedge clk);
        check("busy_clr_same", {31'd0, busy1}, 32'd0);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("busy_clr_after", {31'd0, busy1}, 32'd0);
        check("r7_data", rdata1, 32'h77);
        tick();

        // Simultaneous mark and write on r9: mark wins
        mark_en = 1'b1; mark_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h99; raddr2 = 5'd9;
        @(negedge clk);
        check("r9_bypass", rdata2, 32'h99);
        tick();
        mark_en = 1'b0; we = 1'b0;
        @(negedge clk);
        check("mark_wins", {31'd0, busy2}, 32'd1);
        tick();

        // Non-busy write, both ports on the same address
        we = 1'b1; waddr = 5'd12; wdata = 32'hC0FFEE; raddr1 = 5'd12; raddr2 = 5'd12;
        @(negedge clk);
        check("same_addr_p1", rdata1, 32'hC0FFEE);
        check("same_addr_p2", rdata2, 32'hC0FFEE);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("nonbusy_busy", {31'd0, busy1}, 32'd0);
        check("nonbusy_data", rdata2, 32'hC0FFEE);
        tick();

        // Mixed traffic checked by the model only
        for (int i = 0; i < 60; i++) begin
            we        = ($urandom_range(1, 0) == 1);
            waddr     = 5'($urandom_range(31, 0));
            wdata     = $urandom;
            mark_en   = ($urandom_range(3, 0) == 0);
            mark_addr = 5'($urandom_range(31, 0));
            raddr1    = 5'($urandom_range(31, 0));
            raddr2    = (i % 4 == 0) ? waddr : 5'($urandom_range(31, 0));
            tick();
        end
        we = 1'b0; mark_en = 1'b0;

        // Mid-operation reset, then a second reset during INIT at idx 10
        we = 1'b1; waddr = 5'd3; wdata = 32'hAA; raddr1 = 5'd3; raddr2 = 5'd9;
        mark_en = 1'b1; mark_addr = 5'd9;
        tick();
        we = 1'b0; mark_en = 1'b0;
        @(negedge clk);
        check("r3_written", rdata1, 32'hAA);
        check("r9_marked", {31'd0, busy2}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", {31'd0, ready}, 32'd0);
        tick();
        rst = 1'b0;
        wait_ready(n);
        check("reinit_len", n, 32'd32);
        check("r3_reinit", rdata1, 32'd1);
        check("r9_busy_cleared", {31'd0, busy2}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
